// File: rtl/evt_window_pkg.sv
// Shared types and default sizes for the event-window counter slice.
package evt_window_pkg;

  // Scan controller states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default per-dimension counter width (signed, two's complement).
  localparam int unsigned DEF_CNT_WIDTH = 3;
  // Default number of nested dimensions.
  localparam int unsigned DEF_NUM_DIMS  = 2;

endpackage

// File: rtl/evt_dim_counter.sv
// One signed dimension of the window walker: loads its lower bound on init,
// advances by step when it receives a carry, and wraps back to lower (raising
// a carry out) once count+step would pass the upper bound.
module evt_dim_counter
  import evt_window_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        init_i,
  input  logic                        cnt_en_i,
  input  logic signed [CNT_WIDTH-1:0] lower_i,
  input  logic signed [CNT_WIDTH-1:0] upper_i,
  input  logic        [CNT_WIDTH-1:0] step_i,
  output logic signed [CNT_WIDTH-1:0] count_o,
  output logic                        wrap_o,
  output logic                        at_last_o
);

  // The step is unsigned and can reach 2^W-1, so the sum keeps two guard
  // bits; the upper-bound compare is then exact over the whole range.
  localparam int unsigned EW = CNT_WIDTH + 2;

  logic signed [EW-1:0]        sum_s;
  logic signed [EW-1:0]        upper_ext_s;
  logic                        at_last_s;
  logic signed [CNT_WIDTH-1:0] count_d;
  logic signed [CNT_WIDTH-1:0] count_q;

  // Widened candidate value and end-of-range detection.
  always_comb begin
    sum_s       = EW'(count_q) + $signed({2'b00, step_i});
    upper_ext_s = EW'(upper_i);
    at_last_s   = (sum_s > upper_ext_s);
  end

  // Next count: init load, then advance or wrap only on an incoming carry.
  always_comb begin
    count_d = count_q;
    if (init_i) begin
      count_d = lower_i;
    end else if (cnt_en_i) begin
      if (at_last_s) begin
        count_d = lower_i;
      end else begin
        count_d = sum_s[CNT_WIDTH-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign at_last_o = at_last_s;
  assign wrap_o    = cnt_en_i & at_last_s;

endmodule

// File: rtl/evt_window_counter.sv
// N-dimensional signed window counter: validates and latches the per-dimension
// bounds on start, then issues one offset tuple per valid/ready transfer with
// dim 0 innermost, ending each scan with a done pulse.
module evt_window_counter
  import evt_window_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned NUM_DIMS  = DEF_NUM_DIMS
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [NUM_DIMS*CNT_WIDTH-1:0] cfg_lower_i,
  input  logic [NUM_DIMS*CNT_WIDTH-1:0] cfg_upper_i,
  input  logic [NUM_DIMS*CNT_WIDTH-1:0] cfg_step_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [NUM_DIMS*CNT_WIDTH-1:0] count_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned VW = NUM_DIMS * CNT_WIDTH;

  state_e          state_q, state_d;
  logic [VW-1:0]   lower_q, lower_d;
  logic [VW-1:0]   upper_q, upper_d;
  logic [VW-1:0]   step_q,  step_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;

  logic            cfg_ok_s;
  logic            start_ok_s;
  logic            xfer_s;
  logic            final_xfer_s;
  logic [VW-1:0]   lower_sel_s;
  logic [VW-1:0]   upper_sel_s;
  logic [VW-1:0]   step_sel_s;
  logic [NUM_DIMS-1:0] at_last_s;

  // A configuration is usable only if every dimension has lower<=upper and a nonzero step.
  always_comb begin
    cfg_ok_s = 1'b1;
    for (int unsigned d = 0; d < NUM_DIMS; d++) begin
      if (($signed(cfg_lower_i[d*CNT_WIDTH +: CNT_WIDTH]) >
           $signed(cfg_upper_i[d*CNT_WIDTH +: CNT_WIDTH])) ||
          (cfg_step_i[d*CNT_WIDTH +: CNT_WIDTH] == {CNT_WIDTH{1'b0}})) begin
        cfg_ok_s = 1'b0;
      end else begin
        cfg_ok_s = cfg_ok_s;
      end
    end
  end

  // Handshake qualifiers; in IDLE the counters see the live config so the
  // init load picks up the bounds being latched in the same cycle.
  always_comb begin
    start_ok_s = (state_q == IDLE) & start_i & ~clear_i & cfg_ok_s;
    xfer_s     = (state_q == RUN) & ready_i & ~clear_i;
    if (state_q == IDLE) begin
      lower_sel_s = cfg_lower_i;
      upper_sel_s = cfg_upper_i;
      step_sel_s  = cfg_step_i;
    end else begin
      lower_sel_s = lower_q;
      upper_sel_s = upper_q;
      step_sel_s  = step_q;
    end
  end

  // Per-dimension counters with a ripple carry: dim 0 steps on every
  // transfer, dim d+1 steps when dim d wraps.
  for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
    logic cnt_en_s;
    logic wrap_s;

    if (d == 0) begin : g_first
      assign cnt_en_s = xfer_s;
    end else begin : g_chain
      assign cnt_en_s = g_dim[d-1].wrap_s;
    end

    evt_dim_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_dim (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .init_i    (start_ok_s),
      .cnt_en_i  (cnt_en_s),
      .lower_i   (lower_sel_s[d*CNT_WIDTH +: CNT_WIDTH]),
      .upper_i   (upper_sel_s[d*CNT_WIDTH +: CNT_WIDTH]),
      .step_i    (step_sel_s[d*CNT_WIDTH +: CNT_WIDTH]),
      .count_o   (count_o[d*CNT_WIDTH +: CNT_WIDTH]),
      .wrap_o    (wrap_s),
      .at_last_o (at_last_s[d])
    );
  end

  // The carry out of the outermost dimension is exactly the final transfer.
  assign final_xfer_s = g_dim[NUM_DIMS-1].wrap_s;

  // Next-state, config latch and pulse logic; clear_i overrides everything.
  always_comb begin
    state_d = state_q;
    lower_d = lower_q;
    upper_d = upper_q;
    step_d  = step_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok_s) begin
              state_d = RUN;
              lower_d = cfg_lower_i;
              upper_d = cfg_upper_i;
              step_d  = cfg_step_i;
            end else begin
              err_d   = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (final_xfer_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller state, latched configuration and registered pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lower_q <= {VW{1'b0}};
      upper_q <= {VW{1'b0}};
      step_q  <= {VW{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = (state_q == RUN);
  assign busy_o  = (state_q == RUN);
  assign last_o  = (state_q == RUN) & (&at_last_s);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_evt_window_counter.sv
// Directed self-checking bench for evt_window_counter (CNT_WIDTH=3, NUM_DIMS=2).
module tb_evt_window_counter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clear_i = 1'b0;
  logic       start_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [5:0] cfg_lower_i = 6'd0;
  logic [5:0] cfg_upper_i = 6'd0;
  logic [5:0] cfg_step_i = 6'd0;
  logic       valid_o, last_o, busy_o, done_o, err_o;
  logic [5:0] count_o;

  int checks = 0;
  int errors = 0;
  int ex[$];
  int ey[$];

  evt_window_counter #(.CNT_WIDTH(3), .NUM_DIMS(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .cfg_lower_i (cfg_lower_i),
    .cfg_upper_i (cfg_upper_i),
    .cfg_step_i  (cfg_step_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [5:0] pack2(input int x, input int y);
    logic [2:0] xb, yb;
    xb = x[2:0];
    yb = y[2:0];
    return {yb, xb};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int lo0, input int hi0, input int st0,
                         input int lo1, input int hi1, input int st1);
    cfg_lower_i = pack2(lo0, lo1);
    cfg_upper_i = pack2(hi0, hi1);
    cfg_step_i  = pack2(st0, st1);
  endtask

  // Reference tuple order: dim 0 innermost.
  task automatic build_exp(input int lo0, input int hi0, input int st0,
                           input int lo1, input int hi1, input int st1);
    ex.delete();
    ey.delete();
    for (int y = lo1; y <= hi1; y += st1) begin
      for (int x = lo0; x <= hi0; x += st0) begin
        ex.push_back(x);
        ey.push_back(y);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", last_o); end
    checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: done %b err %b want 0 0", done_o, err_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL reset_count: got %h want 00", count_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  // Full scans at ready=1 over a table of configurations.
  task automatic test_scan_patterns();
    int cfgs[4][6] = '{'{-1, 1, 1, -1, 1, 1},
                       '{-3, 2, 2,  0, 1, 1},
                       '{-4, 3, 3, -4, 3, 7},
                       '{ 0, 0, 1,  0, 0, 1}};
    for (int c = 0; c < 4; c++) begin
      int n;
      set_cfg(cfgs[c][0], cfgs[c][1], cfgs[c][2], cfgs[c][3], cfgs[c][4], cfgs[c][5]);
      build_exp(cfgs[c][0], cfgs[c][1], cfgs[c][2], cfgs[c][3], cfgs[c][4], cfgs[c][5]);
      n = ex.size();
      ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < n; i++) begin
        checks++; if (valid_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL scan%0d_valid[%0d]: valid %b busy %b want 1 1", c, i, valid_o, busy_o); end
        checks++; if (count_o !== pack2(ex[i], ey[i])) begin errors++; $display("FAIL scan%0d_count[%0d]: got %h want %h", c, i, count_o, pack2(ex[i], ey[i])); end
        checks++; if (last_o !== (i == n - 1)) begin errors++; $display("FAIL scan%0d_last[%0d]: got %b want %b", c, i, last_o, (i == n - 1)); end
        tick();
      end
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL scan%0d_end: valid %b busy %b done %b want 0 0 1", c, valid_o, busy_o, done_o); end
      tick();
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL scan%0d_done_pulse: got %b want 0", c, done_o); end
    end
  endtask

  // 3x3 scan with ready pattern 1,0,0,1 repeating.
  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int idx = 0;
    int cyc = 0;
    set_cfg(-1, 1, 1, -1, 1, 1);
    build_exp(-1, 1, 1, -1, 1, 1);
    ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (idx < 9 && cyc < 100) begin
      checks++; if (valid_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL bp_valid[%0d]: valid %b done %b want 1 0", cyc, valid_o, done_o); end
      checks++; if (count_o !== pack2(ex[idx], ey[idx])) begin errors++; $display("FAIL bp_count[%0d]: got %h want %h", cyc, count_o, pack2(ex[idx], ey[idx])); end
      checks++; if (last_o !== (idx == 8)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", cyc, last_o, (idx == 8)); end
      ready_i = pat[cyc % 4];
      if (ready_i) idx++;
      cyc++;
      tick();
    end
    checks++; if (idx != 9) begin errors++; $display("FAIL bp_timeout: transfers %0d want 9", idx); end
    checks++; if (valid_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL bp_end: valid %b done %b want 0 1", valid_o, done_o); end
    ready_i = 1'b1;
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL bp_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_config_error();
    set_cfg(2, 1, 1, -1, 1, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (err_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL cfgerr_pulse: err %b valid %b busy %b want 1 0 0", err_o, valid_o, busy_o); end
    tick();
    checks++; if (err_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL cfgerr_after: err %b valid %b want 0 0", err_o, valid_o); end
    set_cfg(0, 1, 0, 0, 1, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (err_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL cfgerr_step0: err %b valid %b want 1 0", err_o, valid_o); end
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    checks++; if (err_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL clear_start_bad: err %b valid %b want 0 0", err_o, valid_o); end
    set_cfg(-1, 1, 1, -1, 1, 1);
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    checks++; if (err_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL clear_start_good: err %b valid %b busy %b want 0 0 0", err_o, valid_o, busy_o); end
  endtask

  task automatic test_clear_mid_scan();
    set_cfg(-1, 1, 1, -1, 1, 1);
    build_exp(-1, 1, 1, -1, 1, 1);
    ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (count_o !== pack2(ex[i], ey[i])) begin errors++; $display("FAIL clr_count[%0d]: got %h want %h", i, count_o, pack2(ex[i], ey[i])); end
      if (i == 3) clear_i = 1'b1;
      tick();
    end
    clear_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL clr_idle: valid %b done %b busy %b want 0 0 0", valid_o, done_o, busy_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || count_o !== pack2(-1, -1)) begin errors++; $display("FAIL clr_restart: valid %b count %h want 1 %h", valid_o, count_o, pack2(-1, -1)); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // Single-point window restarted the cycle after its done pulse.
  task automatic test_back_to_back();
    set_cfg(0, 0, 1, 0, 0, 1);
    ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || last_o !== 1'b1 || count_o !== 6'd0) begin errors++; $display("FAIL b2b_first: valid %b last %b count %h want 1 1 00", valid_o, last_o, count_o); end
    tick();
    checks++; if (done_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL b2b_done: done %b valid %b want 1 0", done_o, valid_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || last_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL b2b_restart: valid %b last %b done %b want 1 1 0", valid_o, last_o, done_o); end
    tick();
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done_o); end
    tick();
  endtask

  task automatic test_async_reset();
    set_cfg(-1, 1, 1, -1, 1, 1);
    ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #3;
    rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || last_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL areset_ctrl: valid %b busy %b last %b done %b want 0 0 0 0", valid_o, busy_o, last_o, done_o); end
    checks++; if (count_o !== 6'd0) begin errors++; $display("FAIL areset_count: got %h want 00", count_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_scan_patterns();
    test_backpressure();
    test_config_error();
    test_clear_mid_scan();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
